// File: rtl/axi_sm4_lite_slave_if.sv
// AXI4-Lite bus bundle for the SM4 register slave.
// The slave modport is the register block's view; master is the bus driver's view.
interface axi_sm4_lite_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_sm4_lite_slave.sv
// AXI4-Lite register front end for an SM4 block-cipher core (DIN/KEY/CTRL/STATUS/DOUT).
// Define AXI_SM4_IRQ_EN to add the irq output and the CTRL.IRQ_ENABLE bit.
module axi_sm4_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    axi_sm4_lite_slave_if.slave       s_axi,
    output logic                      core_start,
    output logic                      core_mode,
    output logic [127:0]              core_data,
    output logic [127:0]              core_key,
    input  logic                      core_done,
    input  logic [127:0]              core_result
`ifdef AXI_SM4_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0]              idx_t;

    localparam idx_t IDX_CTRL   = idx_t'(8);
    localparam idx_t IDX_STATUS = idx_t'(9);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    word_t din  [4];
    word_t key  [4];
    word_t dout [4];
    logic  mode;
    logic  busy;
    logic  done;
`ifdef AXI_SM4_IRQ_EN
    logic  irq_en;
`endif

    logic  aw_ready_q;
    logic  ar_ready_q;
    logic  bvalid_q;
    logic  rvalid_q;

    idx_t  wr_idx;
    idx_t  rd_idx;
    logic  wr_fire;
    logic  rd_fire;
    logic  wr_err;
    logic  start_fire;
    logic  done_clr;
    logic  done_set;
    word_t rd_word;
    logic  rd_err;

    // Byte offset bits carry no information for word-aligned registers.
    logic  unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    function automatic word_t merge_bytes(input word_t old_val, input word_t new_val,
                                          input logic [STRB_W-1:0] strb);
        word_t res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign wr_idx     = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx     = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire    = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire    = ar_ready_q && s_axi.arvalid;
    assign wr_err     = (wr_idx >= idx_t'(14));
    assign start_fire = wr_fire && (wr_idx == IDX_CTRL) && s_axi.wstrb[0]
                        && s_axi.wdata[0] && !busy;
    assign done_clr   = wr_fire && (wr_idx == IDX_STATUS) && s_axi.wstrb[0] && s_axi.wdata[1];
    assign done_set   = core_done && busy;

    assign core_mode  = mode;
    assign core_data  = {din[0], din[1], din[2], din[3]};
    assign core_key   = {key[0], key[1], key[2], key[3]};

    // ------------------------------------------------------------------
    // Write channel: AW and W are taken together, one transaction per B
    // ------------------------------------------------------------------
    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = aw_ready_q;
    assign s_axi.bvalid  = bvalid_q;

    // NOTE: state is updated with non-blocking assignments so every block
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_ready_q  <= 1'b0;
            bvalid_q    <= 1'b0;
            s_axi.bresp <= RESP_OKAY;
        end else begin
            aw_ready_q <= s_axi.awvalid && s_axi.wvalid && !bvalid_q && !aw_ready_q;
            if (wr_fire) begin
                bvalid_q    <= 1'b1;
                s_axi.bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and core sequencing
    // ------------------------------------------------------------------
    // NOTE: the register arrays are real flops read back over the bus, so
    // they are reset like any other state rather than left as RAM.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) begin
                din[i]  <= '0;
                key[i]  <= '0;
                dout[i] <= '0;
            end
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_start <= 1'b0;
`ifdef AXI_SM4_IRQ_EN
            irq_en     <= 1'b0;
`endif
        end else begin
            core_start <= start_fire;

            // Operand and mode registers are frozen while the core works.
            if (wr_fire && !busy) begin
                case (wr_idx)
                    idx_t'(0), idx_t'(1), idx_t'(2), idx_t'(3):
                        din[wr_idx[1:0]] <= merge_bytes(din[wr_idx[1:0]], s_axi.wdata, s_axi.wstrb);
                    idx_t'(4), idx_t'(5), idx_t'(6), idx_t'(7):
                        key[wr_idx[1:0]] <= merge_bytes(key[wr_idx[1:0]], s_axi.wdata, s_axi.wstrb);
                    IDX_CTRL:
                        if (s_axi.wstrb[0]) mode <= s_axi.wdata[1];
                    default: ;
                endcase
            end

`ifdef AXI_SM4_IRQ_EN
            if (wr_fire && (wr_idx == IDX_CTRL) && s_axi.wstrb[0]) irq_en <= s_axi.wdata[2];
`endif

            if (start_fire) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (done_clr) begin
                done <= 1'b0;
            end

            // Completion comes last so a coincident W1C cannot hide it.
            if (done_set) begin
                busy <= 1'b0;
                done <= 1'b1;
                for (int i = 0; i < 4; i++) dout[i] <= core_result[(3-i)*32 +: 32];
            end
        end
    end

`ifdef AXI_SM4_IRQ_EN
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) irq <= 1'b0;
        else              irq <= done && irq_en;
    end
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    // NOTE: every output of this always_comb gets a default first so no
    // path through the case can infer a latch.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            idx_t'(0), idx_t'(1), idx_t'(2), idx_t'(3):
                rd_word = din[rd_idx[1:0]];
            idx_t'(4), idx_t'(5), idx_t'(6), idx_t'(7):
                rd_word = key[rd_idx[1:0]];
            IDX_CTRL: begin
                rd_word[1] = mode;
`ifdef AXI_SM4_IRQ_EN
                rd_word[2] = irq_en;
`endif
            end
            IDX_STATUS:
                rd_word[1:0] = {done, busy};
            // DOUT0..3 sit at indices 10..13; adding 2 mod 4 maps them to 0..3.
            idx_t'(10), idx_t'(11), idx_t'(12), idx_t'(13):
                rd_word = dout[rd_idx[1:0] + 2'd2];
            default:
                rd_err = 1'b1;
        endcase
    end

    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = rvalid_q;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ar_ready_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            s_axi.rdata <= '0;
            s_axi.rresp <= RESP_OKAY;
        end else begin
            ar_ready_q <= s_axi.arvalid && !rvalid_q && !ar_ready_q;
            if (rd_fire) begin
                rvalid_q    <= 1'b1;
                s_axi.rdata <= rd_word;
                s_axi.rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_sm4_lite_slave.sv
// Directed, scoreboard-driven bench for axi_sm4_lite_slave.
// Expected responses are queued when a transaction is issued and compared when it returns.
module tb_axi_sm4_lite_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [127:0] VEC  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] RES1 = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] RES2 = 128'h00112233445566778899AABBCCDDEEFF;
`ifdef AXI_SM4_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h6;
`else
    localparam logic [31:0] CTRL_RB = 32'h2;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         core_start;
    logic         core_mode;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
`ifdef AXI_SM4_IRQ_EN
    logic         irq;
`endif

    int   total = 0;
    int   bad = 0;
    int   start_cnt = 0;
    exp_t sb_q[$];

    axi_sm4_lite_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    axi_sm4_lite_slave dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_data    (core_data),
        .core_key     (core_key),
        .core_done    (core_done),
        .core_result  (core_result)
`ifdef AXI_SM4_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start) start_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input bit done_at_accept = 1'b0,
                             input logic [127:0] result = '0);
        exp_t e;
        int   n;
        sb_q.push_back('{data: 32'h0, resp: exp_resp});
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.awready && n < 20);
        check("awready", bus.awready, 1'b1);
        if (done_at_accept) begin
            core_done   = 1'b1;
            core_result = result;
        end
        @(posedge clk); #1;
        core_done   = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        e = sb_q.pop_front();
        check("bresp", {bus.bvalid, bus.bresp}, {1'b1, e.resp});
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        exp_t e;
        int   n;
        sb_q.push_back('{data: exp_data, resp: exp_resp});
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.arready && n < 20);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        e = sb_q.pop_front();
        check({tag, "_rvalid"}, bus.rvalid, 1'b1);
        check({tag, "_rdata"}, bus.rdata, e.data);
        check({tag, "_rresp"}, bus.rresp, e.resp);
        @(posedge clk); #1;
    endtask

    task automatic pulse_done(input logic [127:0] result);
        core_done   = 1'b1;
        core_result = result;
        @(posedge clk); #1;
        core_done   = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready",  bus.wready,  1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_bresp",   bus.bresp,   2'b00);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_rdata",   bus.rdata,   32'h0);
        check("rst_rresp",   bus.rresp,   2'b00);
        check("rst_core_start", core_start, 1'b0);
        check("rst_core_data",  core_data,  128'h0);
        check("rst_core_key",   core_key,   128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(6'h24, 32'h0, OKAY, "rst_status");
        axi_read(6'h28, 32'h0, OKAY, "rst_dout0");

        // DIN write/readback
        axi_write(6'h00, 32'h1, 4'hF, OKAY);
        axi_write(6'h04, 32'h2, 4'hF, OKAY);
        axi_write(6'h08, 32'h3, 4'hF, OKAY);
        axi_write(6'h0C, 32'h4, 4'hF, OKAY);
        axi_read(6'h00, 32'h1, OKAY, "din0");
        axi_read(6'h04, 32'h2, OKAY, "din1");
        axi_read(6'h08, 32'h3, OKAY, "din2");
        axi_read(6'h0C, 32'h4, OKAY, "din3");

        // Byte strobes merge into the old value
        axi_write(6'h00, 32'hAABBCCDD, 4'b0101, OKAY);
        axi_read(6'h00, 32'h00BB00DD, OKAY, "din0_strb");

        // CTRL readback: START reads 0, MODE sticks, IRQ_ENABLE only when built in
        axi_write(6'h20, 32'h6, 4'hF, OKAY);
        axi_read(6'h20, CTRL_RB, OKAY, "ctrl_rb");
        check("core_mode_set", core_mode, 1'b1);
        axi_write(6'h20, 32'h0, 4'hF, OKAY);
        check("core_mode_clr", core_mode, 1'b0);

        // Standard vector into KEY and DIN
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(6'h10 + 4*i), VEC[(3-i)*32 +: 32], 4'hF, OKAY);
            axi_write(6'(6'h00 + 4*i), VEC[(3-i)*32 +: 32], 4'hF, OKAY);
        end
        check("core_key_vec",  core_key,  VEC);
        check("core_data_vec", core_data, VEC);

        // core_done while idle is ignored
        pulse_done(RES2);
        axi_read(6'h28, 32'h0, OKAY, "dout0_idle_done");

        // Launch
        axi_write(6'h20, 32'h1, 4'hF, OKAY);
        check("start_cnt_1", start_cnt, 1);
        axi_read(6'h24, 32'h1, OKAY, "status_busy");

        // Writes while busy are ignored but answered OKAY
        axi_write(6'h00, 32'hDEADBEEF, 4'hF, OKAY);
        axi_write(6'h20, 32'h3, 4'hF, OKAY);
        check("start_cnt_busy", start_cnt, 1);
        check("core_mode_frozen", core_mode, 1'b0);
        check("core_data_frozen", core_data, VEC);
        axi_read(6'h00, 32'h01234567, OKAY, "din0_frozen");

        // Completion
        pulse_done(RES1);
        axi_read(6'h24, 32'h2, OKAY, "status_done");
        axi_read(6'h28, 32'h681EDF34, OKAY, "dout0");
        axi_read(6'h2C, 32'hD206965E, OKAY, "dout1");
        axi_read(6'h30, 32'h86B3E94F, OKAY, "dout2");
        axi_read(6'h34, 32'h536E4246, OKAY, "dout3");

        // RO write ignored, W1C of DONE
        axi_write(6'h28, 32'hFFFFFFFF, 4'hF, OKAY);
        axi_read(6'h28, 32'h681EDF34, OKAY, "dout0_ro");
        axi_write(6'h24, 32'h2, 4'hF, OKAY);
        axi_read(6'h24, 32'h0, OKAY, "status_w1c");

        // W1C coinciding with completion: set wins
        axi_write(6'h20, 32'h1, 4'hF, OKAY);
        check("start_cnt_2", start_cnt, 2);
        axi_write(6'h24, 32'h2, 4'hF, OKAY, 1'b1, RES2);
        axi_read(6'h24, 32'h2, OKAY, "status_set_prio");
        axi_read(6'h34, 32'hCCDDEEFF, OKAY, "dout3_res2");

        // Unmapped addresses
        axi_write(6'h3C, 32'h12345678, 4'hF, SLVERR);
        axi_read(6'h38, 32'h0, SLVERR, "unmapped_38");
        axi_read(6'h3C, 32'h0, SLVERR, "unmapped_3c");
        check("start_cnt_unmapped", start_cnt, 2);

        // Back-pressure on B with a second write pending
        bus.bready  = 1'b0;
        bus.awaddr  = 6'h04;
        bus.wdata   = 32'h11111111;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        sb_q.push_back('{data: 32'h0, resp: OKAY});
        sb_q.push_back('{data: 32'h0, resp: OKAY});
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.awready && n < 20);
        check("bp_first_awready", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awaddr = 6'h08;
        bus.wdata  = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold",  bus.bvalid,  1'b1);
            check("bp_awready_low",  bus.awready, 1'b0);
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        check("bp_bresp1", bus.bresp, e.resp);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!bus.awready && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_second_awready", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        e = sb_q.pop_front();
        check("bp_bresp2", {bus.bvalid, bus.bresp}, {1'b1, e.resp});
        @(posedge clk); #1;
        axi_read(6'h04, 32'h11111111, OKAY, "bp_din1");
        axi_read(6'h08, 32'h22222222, OKAY, "bp_din2");

        // Reset mid-operation abandons the core run
        axi_write(6'h20, 32'h1, 4'hF, OKAY);
        check("start_cnt_3", start_cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_core_start", core_start, 1'b0);
        check("midrst_core_data", core_data, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_done(RES1);
        axi_read(6'h24, 32'h0, OKAY, "midrst_status");
        axi_read(6'h28, 32'h0, OKAY, "midrst_dout0");
        axi_read(6'h00, 32'h0, OKAY, "midrst_din0");
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
